// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-granular round-robin arbiter sharing the UART TX FIFO write port among
// N_REQ byte-stream requesters, with a mid-frame stall watchdog.
// Optional feature macro: UART_TX_CRLF_EN appends 8'h0D, 8'h0A after every completed frame.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               UART_Full,
    output logic [7:0]         UART_Din,
    output logic               UART_WR_EN,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_abort
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_CR, S_LF} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    r_rr_ptr, w_rr_nxt;
    logic [IW-1:0]    w_win, w_owner_inc;
    logic [IW:0]      w_idx;
    logic             w_found;
    logic [SW-1:0]    r_stall_cnt, w_stall_nxt;
    logic             r_done, w_done_nxt;
    logic             r_abort, w_abort_nxt;
    logic             w_xfer, w_stall;

    assign grant       = r_grant;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + IW'(1);

    // Round-robin search: first valid requester starting at r_rr_ptr, wrapping mod N_REQ
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(N_REQ)) w_idx = w_idx - (IW+1)'(N_REQ);
            if (!w_found && req_valid[w_idx[IW-1:0]]) begin
                w_win   = w_idx[IW-1:0];
                w_found = 1'b1;
            end
        end
    end

    // Next-state and FIFO-side outputs; a write only ever happens while the FIFO is not full
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_stall_nxt = r_stall_cnt;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        w_xfer      = 1'b0;
        w_stall     = 1'b0;
        req_ready   = '0;
        UART_WR_EN  = 1'b0;
        UART_Din    = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_stall_nxt = '0;
                if (w_found) begin
                    w_grant_nxt = N_REQ'(1) << w_win;
                    w_owner_nxt = w_win;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                UART_Din           = req_data[{r_owner, 3'b000} +: 8];
                req_ready[r_owner] = !UART_Full;
                w_xfer             = req_valid[r_owner] && !UART_Full;
                w_stall            = !req_valid[r_owner] && !UART_Full;
                UART_WR_EN         = w_xfer;
                if (w_xfer) begin
                    w_stall_nxt = '0;
                    if (req_last[r_owner]) begin
`ifdef UART_TX_CRLF_EN
                        w_state_nxt = S_CR;
`else
                        w_grant_nxt = '0;
                        w_rr_nxt    = w_owner_inc;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
`endif
                    end
                end else if (w_stall && TIMEOUT_CYC != 0) begin
                    if (r_stall_cnt == STALL_MAX) begin
                        w_grant_nxt = '0;
                        w_rr_nxt    = w_owner_inc;
                        w_stall_nxt = '0;
                        w_state_nxt = S_IDLE;
                        w_abort_nxt = 1'b1;
                    end else begin
                        w_stall_nxt = r_stall_cnt + SW'(1);
                    end
                end
            end
`ifdef UART_TX_CRLF_EN
            S_CR: begin
                UART_Din   = 8'h0D;
                UART_WR_EN = !UART_Full;
                if (!UART_Full) w_state_nxt = S_LF;
            end
            S_LF: begin
                UART_Din   = 8'h0A;
                UART_WR_EN = !UART_Full;
                if (!UART_Full) begin
                    w_grant_nxt = '0;
                    w_rr_nxt    = w_owner_inc;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, ownership, round-robin pointer, watchdog and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_done      <= w_done_nxt;
            r_abort     <= w_abort_nxt;
        end
    end
endmodule
